// File: rtl/jtag_types_pkg.sv
// Shared JTAG types: TAP state encoding and instruction register type.
package jtag_types_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned IR_W    = 4;

    // Encoding follows the customary IEEE 1149.1 state codes so debug dumps read familiarly.
    typedef enum logic [STATE_W-1:0] {
        EXIT2_DR = 4'h0,
        EXIT1_DR = 4'h1,
        SHIFT_DR = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EXIT2_IR = 4'h8,
        EXIT1_IR = 4'h9,
        SHIFT_IR = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } tap_state_t;

    typedef logic [IR_W-1:0] instruction_t;

    localparam instruction_t BYPASS = instruction_t'({IR_W{1'b1}});

endpackage

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM clocked by TCK, Moore decode of the
// IR/DR capture/shift/update strobes, path select and TDO mux.
// Ports:
//   TCK, TRST            clock, synchronous active-high reset
//   TMS                  test mode select
//   ir_tdo, dr_tdo       serial outputs of the IR and selected DR
//   ir_*/dr_* controls   capture/shift/update strobes (at most one high)
//   tlr_reset            high while in TLR
//   test_reset           one-cycle pulse on FSM entry to TLR (not on TRST)
//   select               1 = IR path, 0 = DR path
//   tdo, tdo_en          muxed serial out and its valid flag
//   state                current TAP state for debug
module tap_controller
    import jtag_types_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    input  logic       ir_tdo,
    input  logic       dr_tdo,
    output logic       ir_capture,
    output logic       ir_shift,
    output logic       ir_update,
    output logic       dr_capture,
    output logic       dr_shift,
    output logic       dr_update,
    output logic       tlr_reset,
    output logic       test_reset,
    output logic       select,
    output logic       tdo,
    output logic       tdo_en,
    output logic [3:0] state
);

    tap_state_t state_q;
    tap_state_t state_d;
    logic       test_reset_q;
    logic       test_reset_d;

    // State register.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:      state_d = TMS ? TLR      : RTI;
            RTI:      state_d = TMS ? SEL_DR   : RTI;
            SEL_DR:   state_d = TMS ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = TMS ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_d = TMS ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_d = TMS ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = TMS ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_d = TMS ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_d = TMS ? SEL_DR   : RTI;
            SEL_IR:   state_d = TMS ? TLR      : CAP_IR;
            CAP_IR:   state_d = TMS ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_d = TMS ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_d = TMS ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = TMS ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_d = TMS ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_d = TMS ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    // Moore output decode from the current state.
    always_comb begin
        ir_capture = 1'b0;
        ir_shift   = 1'b0;
        ir_update  = 1'b0;
        dr_capture = 1'b0;
        dr_shift   = 1'b0;
        dr_update  = 1'b0;
        tlr_reset  = 1'b0;
        select     = 1'b0;
        unique case (state_q)
            TLR:      tlr_reset  = 1'b1;
            CAP_DR:   dr_capture = 1'b1;
            SHIFT_DR: dr_shift   = 1'b1;
            UPD_DR:   dr_update  = 1'b1;
            SEL_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR: select = 1'b1;
            CAP_IR: begin
                select     = 1'b1;
                ir_capture = 1'b1;
            end
            SHIFT_IR: begin
                select   = 1'b1;
                ir_shift = 1'b1;
            end
            UPD_IR: begin
                select    = 1'b1;
                ir_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Pulse only when the FSM walks into TLR; a TRST-forced entry stays quiet.
    always_comb begin
        test_reset_d = (state_d == TLR) && (state_q != TLR);
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            test_reset_q <= 1'b0;
        end else begin
            test_reset_q <= test_reset_d;
        end
    end

    assign tdo_en     = ir_shift | dr_shift;
    assign tdo        = tdo_en & (select ? ir_tdo : dr_tdo);
    assign test_reset = test_reset_q;
    assign state      = 4'(state_q);

endmodule

// File: tb/tb_tap_controller.sv
// Bench for tap_controller: directed scans plus random TMS/TRST against a
// table-driven reference of the TAP state graph.
module tb_tap_controller;
    import jtag_types_pkg::*;

    logic       TCK = 1'b0;
    logic       TRST = 1'b1;
    logic       TMS = 1'b0;
    logic       ir_tdo = 1'b0;
    logic       dr_tdo = 1'b0;
    logic       ir_capture, ir_shift, ir_update;
    logic       dr_capture, dr_shift, dr_update;
    logic       tlr_reset, test_reset, select, tdo, tdo_en;
    logic [3:0] state;

    tap_controller dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .ir_tdo     (ir_tdo),
        .dr_tdo     (dr_tdo),
        .ir_capture (ir_capture),
        .ir_shift   (ir_shift),
        .ir_update  (ir_update),
        .dr_capture (dr_capture),
        .dr_shift   (dr_shift),
        .dr_update  (dr_update),
        .tlr_reset  (tlr_reset),
        .test_reset (test_reset),
        .select     (select),
        .tdo        (tdo),
        .tdo_en     (tdo_en),
        .state      (state)
    );

    always #5 TCK = ~TCK;

    // Model states are indices in the order the states are listed in the
    // standard: TLR, RTI, SEL_DR, then the six DR branch states, SEL_IR, then
    // the six IR branch states. Branch offset: 0 CAP,1 SHIFT,2 EXIT1,3 PAUSE,4 EXIT2,5 UPD.
    localparam int M_TLR     = 0;
    localparam int M_RTI     = 1;
    localparam int M_SEL_DR  = 2;
    localparam int M_DR_BASE = 3;
    localparam int M_SEL_IR  = 9;
    localparam int M_IR_BASE = 10;

    tap_state_t enc [16] = '{TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR,
                             EXIT2_DR, UPD_DR, SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR,
                             PAUSE_IR, EXIT2_IR, UPD_IR};

    int         n_cmp = 0;
    int         n_err = 0;
    int         m_idx = M_TLR;
    bit         m_tr = 1'b0;
    int         ones_run = 0;
    tap_state_t exp_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transitions within a DR/IR branch, shared by both branches.
    function automatic int branch_next(input int off, input bit tms);
        int r;
        case (off)
            0, 1:    r = tms ? 2 : 1;
            2:       r = tms ? 5 : 3;
            3:       r = tms ? 4 : 3;
            default: r = tms ? 5 : 1;
        endcase
        return r;
    endfunction

    function automatic int ref_next(input int s, input bit tms);
        int base;
        if (s == M_TLR)    return tms ? M_TLR    : M_RTI;
        if (s == M_RTI)    return tms ? M_SEL_DR : M_RTI;
        if (s == M_SEL_DR) return tms ? M_SEL_IR : M_DR_BASE;
        if (s == M_SEL_IR) return tms ? M_TLR    : M_IR_BASE;
        base = (s >= M_IR_BASE) ? M_IR_BASE : M_DR_BASE;
        if (s - base == 5) return tms ? M_SEL_DR : M_RTI;
        return base + branch_next(s - base, tms);
    endfunction

    task automatic check_outputs();
        bit ir, in_br, cap, sh, upd, exp_tdo;
        int off;
        ir    = (m_idx >= M_SEL_IR);
        in_br = (m_idx >= M_DR_BASE && m_idx < M_SEL_IR) || (m_idx >= M_IR_BASE);
        off   = m_idx - (ir ? M_IR_BASE : M_DR_BASE);
        cap   = in_br && off == 0;
        sh    = in_br && off == 1;
        upd   = in_br && off == 5;
        exp_tdo = sh && (ir ? ir_tdo : dr_tdo);
        check("state",      int'(state),  int'(enc[m_idx]));
        check("tlr_reset",  tlr_reset,    int'(m_idx == M_TLR));
        check("test_reset", test_reset,   m_tr);
        check("ir_capture", ir_capture,   cap && ir);
        check("ir_shift",   ir_shift,     sh && ir);
        check("ir_update",  ir_update,    upd && ir);
        check("dr_capture", dr_capture,   cap && !ir);
        check("dr_shift",   dr_shift,     sh && !ir);
        check("dr_update",  dr_update,    upd && !ir);
        check("select",     select,       ir);
        check("tdo_en",     tdo_en,       sh);
        check("tdo",        tdo,          exp_tdo);
        check("onehot", int'($countones({ir_capture, ir_shift, ir_update,
                                         dr_capture, dr_shift, dr_update}) <= 1), 1);
    endtask

    // Drive one TCK cycle: inputs change on negedge, outputs checked on the next negedge.
    task automatic tick(input bit tms_v, input bit trst_v);
        int nxt;
        TMS    = tms_v;
        TRST   = trst_v;
        ir_tdo = 1'($urandom);
        dr_tdo = 1'($urandom);
        @(posedge TCK);
        nxt      = trst_v ? M_TLR : ref_next(m_idx, tms_v);
        m_tr     = !trst_v && nxt == M_TLR && m_idx != M_TLR;
        m_idx    = nxt;
        ones_run = (tms_v && !trst_v) ? ones_run + 1 : 0;
        @(negedge TCK);
        check_outputs();
        if (ones_run >= 5) check("five_ones_tlr", int'(state), int'(TLR));
    endtask

    task automatic run_tms(input string s);
        for (int i = 0; i < s.len(); i++) tick(s[i] == "1", 1'b0);
    endtask

    task automatic scan(input string tag, input string s);
        for (int i = 0; i < s.len(); i++) begin
            tick(s[i] == "1", 1'b0);
            check($sformatf("%s[%0d]", tag, i), int'(state), int'(exp_q[i]));
        end
    endtask

    task automatic escape(input string tag, input string path);
        int pulses;
        run_tms("11111");
        run_tms("0");
        run_tms(path);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0);
            if (test_reset) pulses++;
        end
        check({tag, "_tlr"}, int'(state), int'(TLR));
        tick(1'b1, 1'b0);
        if (test_reset) pulses++;
        check({tag, "_pulses"}, pulses, 1);
    endtask

    initial begin
        // Reset held two cycles, then release into RTI.
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("rst_state",      int'(state), int'(TLR));
        check("rst_tlr_reset",  tlr_reset,   1);
        check("rst_test_reset", test_reset,  0);
        check("rst_tdo",        tdo,         0);
        tick(1'b0, 1'b0);
        check("rst_release", int'(state), int'(RTI));

        exp_q = '{SEL_DR, SEL_IR, CAP_IR, SHIFT_IR, SHIFT_IR, SHIFT_IR, SHIFT_IR,
                  SHIFT_IR, EXIT1_IR, UPD_IR, RTI};
        scan("ir_scan", "11000000110");

        exp_q = '{SEL_DR, CAP_DR, SHIFT_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, PAUSE_DR,
                  EXIT2_DR, SHIFT_DR, EXIT1_DR, UPD_DR, RTI};
        scan("dr_scan", "100010010110");

        // Paths below are applied from RTI.
        escape("esc_shift_ir", "1100");
        escape("esc_pause_dr", "1010");
        escape("esc_upd_dr",   "1011");

        // Reset asserted in the middle of a DR shift.
        run_tms("11111");
        run_tms("0100");
        check("mid_in_shift", int'(state), int'(SHIFT_DR));
        tick(1'b0, 1'b1);
        check("mid_state",      int'(state), int'(TLR));
        check("mid_dr_shift",   dr_shift,    0);
        check("mid_tdo_en",     tdo_en,      0);
        check("mid_test_reset", test_reset,  0);
        tick(1'b1, 1'b0);
        check("mid_no_pulse",   test_reset,  0);

        // Random TMS with rare TRST; TMS biased low so deep states are visited.
        for (int i = 0; i < 10000; i++) begin
            tick($urandom_range(0, 99) < 35, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 SHALL have port: TCK  input  1  sole clock; all state updates on posedge TCK.
REQ-002 SHALL have port: TRST  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: TMS  input  1  test mode select, sampled on posedge TCK.
REQ-004 SHALL have port: ir_tdo  input  1  serial out of instruction register.
REQ-005 SHALL have port: dr_tdo  input  1  serial out of selected data register.
REQ-006 SHALL have ports: ir_capture, ir_shift, ir_update  output  1 each  instruction register controls.
REQ-007 SHALL have ports: dr_capture, dr_shift, dr_update  output  1 each  data register controls.
REQ-008 SHALL have port: tlr_reset  output  1  high while in TEST_LOGIC_RESET.
REQ-009 SHALL have port: test_reset  output  1  one-cycle pulse on entry to TEST_LOGIC_RESET.
REQ-010 SHALL have port: select  output  1  1 = IR path, 0 = DR path.
REQ-011 SHALL have ports: tdo  output  1  muxed serial out; tdo_en  output  1  tdo valid.
REQ-012 SHALL have port: state  output  4  current TAP state (tap_state_t), for debug.

Function
REQ-013 SHALL implement the 16-state IEEE 1149.1 TAP FSM: TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR, plus the six IR equivalents and SEL_IR.
REQ-014 SHALL use these transitions (TMS=0 / TMS=1): TLR->RTI/TLR; RTI->RTI/SEL_DR; SEL_DR->CAP_DR/SEL_IR; SEL_IR->CAP_IR/TLR.
REQ-015 SHALL use these transitions (TMS=0 / TMS=1), identical for DR and IR branches: CAP->SHIFT/EXIT1; SHIFT->SHIFT/EXIT1; EXIT1->PAUSE/UPD; PAUSE->PAUSE/EXIT2; EXIT2->SHIFT/UPD; UPD->RTI/SEL_DR.
REQ-016 SHALL advance exactly one state per posedge TCK; no other state changes.
REQ-017 SHALL decode each control output combinationally from the current state (Moore): ir_capture=CAP_IR, ir_shift=SHIFT_IR, ir_update=UPD_IR; DR outputs likewise.
REQ-018 SHALL drive tlr_reset high exactly when state==TLR.
REQ-019 SHALL register test_reset high for the single cycle after any transition into TLR from another state; staying in TLR SHALL NOT re-pulse.
REQ-020 SHALL drive select=1 in SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR, and 0 in all other states.
REQ-021 SHALL drive tdo_en=1 only in SHIFT_IR or SHIFT_DR.
REQ-022 SHALL drive tdo = ir_tdo when select=1, else dr_tdo; tdo SHALL be 0 when tdo_en=0.
REQ-023 SHALL reach TLR within five posedges of TMS=1 from any state.
REQ-024 SHALL assert at most one of the six capture/shift/update outputs in any cycle.

Reset
REQ-025 SHALL, on any posedge with TRST=1, force state to TLR regardless of TMS, including mid-shift.
REQ-026 SHALL hold these output values during and immediately after reset: tlr_reset=1, test_reset=0, all capture/shift/update=0, select=0, tdo_en=0, tdo=0.
REQ-027 SHALL NOT pulse test_reset on the first cycle after reset release; the FSM is already in TLR.

Structure
REQ-028 SHALL define tap_state_t (4-bit enum, 16 states) in jtag_types_pkg, alongside instruction_t and BYPASS.
REQ-029 SHALL be a single module with no sub-modules; the next-state logic, output decode and test_reset register SHALL be distinct always blocks.

Verification
REQ-030 Reset: TRST=1 for 2 cycles with TMS=0 -> state=TLR, tlr_reset=1, test_reset=0; on release with TMS=0, one posedge -> RTI.
REQ-031 IR scan: from RTI apply TMS 1,1,0,0,0,0,0,0,1,1,0 -> CAP_IR for 1 cycle, SHIFT_IR for 5 cycles with tdo=ir_tdo, tdo_en=1, then EXIT1_IR, UPD_IR (ir_update=1 for 1 cycle), RTI.
REQ-032 DR scan with pause: from RTI apply TMS 1,0,0,0,1,0,0,1,0,1,1,0 -> CAP_DR, SHIFT_DR x2, EXIT1_DR, PAUSE_DR x2 (tdo_en=0), EXIT2_DR, SHIFT_DR, EXIT1_DR, UPD_DR, RTI; select=0 throughout.
REQ-033 Five-ones escape: from SHIFT_IR, PAUSE_DR and UPD_DR, apply TMS=1 for 5 cycles -> TLR reached by the 5th posedge; test_reset pulses exactly once per entry.
REQ-034 Mid-shift reset: in SHIFT_DR, assert TRST=1 for 1 cycle with TMS=0 -> next state TLR, dr_shift=0, tdo_en=0, and no test_reset pulse.
REQ-035 Exhaustive: random TMS for 10k cycles checked against a reference FSM model; assert one-hot controls (REQ-024) and the tdo/tdo_en rules every cycle.
